seq_cla_addsub: RTL and testbench

- Parametrised multi-cycle adder/subtractor. Processes a WIDTH-bit operation one SLICE-bit carry-lookahead slice per clock, rippling the carry through a register between slices.
- Includes the 4-way operand-select front end (b, ~b, 0, all-ones), so it covers add, subtract, increment, decrement and pass-through.
- Has valid/ready handshakes on input and output. It is the sequential building block for the datapath ALU.

---
 rtl/addsub_pkg.sv | 17 +
 rtl/seq_cla_addsub_cla_slice.sv | 53 +++++
 rtl/seq_cla_addsub.sv | 162 ++++++++++++++++
 tb/tb_seq_cla_addsub.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared constants for the sequential carry-lookahead adder/subtractor:
// operand-select codes for B and FSM state encodings.
package addsub_pkg;

    typedef logic [1:0] op_sel_t;
    typedef logic [1:0] state_t;

    localparam op_sel_t OP_ADD_B    = 2'b00;
    localparam op_sel_t OP_ADD_NB   = 2'b01;
    localparam op_sel_t OP_ADD_ZERO = 2'b10;
    localparam op_sel_t OP_ADD_ONES = 2'b11;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/seq_cla_addsub_cla_slice.sv
// cla_slice: combinational SLICE-bit carry-lookahead adder. Every carry is a
// flat generate/propagate sum-of-products of the slice inputs.
module cla_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [SLICE-1:0] gen;
    logic [SLICE-1:0] prop;
    logic [SLICE:0]   carry;

    assign gen      = a & b;
    assign prop     = a ^ b;
    assign carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < SLICE; gi++) begin : g_carry
            logic carry_out;

            // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, with no chaining
            always_comb begin
                logic acc;
                logic term;
                acc = cin;
                for (int k = 0; k <= gi; k++) begin
                    acc = acc & prop[k];
                end
                for (int j = 0; j <= gi; j++) begin
                    term = gen[j];
                    for (int k = j + 1; k <= gi; k++) begin
                        term = term & prop[k];
                    end
                    acc = acc | term;
                end
                carry_out = acc;
            end

            assign carry[gi+1] = carry_out;
        end
    endgenerate

    assign sum   = prop ^ carry[SLICE-1:0];
    assign cout  = carry[SLICE];
    assign c_msb = carry[SLICE-1];

endmodule

// File: rtl/seq_cla_addsub.sv
// Multi-cycle adder/subtractor: one SLICE-bit lookahead slice per clock with a
// registered carry between slices. Define ADDSUB_FLAGS_EN for ovf/zero outputs.
module seq_cla_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
`ifdef ADDSUB_FLAGS_EN
    output logic             ovf,
    output logic             zero,
`endif
    output logic             cout
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

    state_t           state_reg;
    logic [IDXW-1:0]  idx_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] y_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] d_reg;
    logic             cout_reg;

    logic [WIDTH-1:0] y_sel;
    logic [WIDTH-1:0] d_next;
    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_y;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic [SLICE-1:0] a_slices [NSLICE];
    logic [SLICE-1:0] y_slices [NSLICE];

    always_comb begin
        y_sel = b;
        case (op)
            OP_ADD_B:    y_sel = b;
            OP_ADD_NB:   y_sel = ~b;
            OP_ADD_ZERO: y_sel = '0;
            OP_ADD_ONES: y_sel = '1;
            default:     y_sel = b;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_split
            assign a_slices[gi] = a_reg[gi*SLICE +: SLICE];
            assign y_slices[gi] = y_reg[gi*SLICE +: SLICE];
        end
    endgenerate

    assign slice_a = a_slices[idx_reg];
    assign slice_y = y_slices[idx_reg];

`ifdef ADDSUB_FLAGS_EN
    logic slice_c_msb;
    logic ovf_reg;
    logic zero_reg;
`else
    logic c_msb_unused;
`endif

    cla_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a     (slice_a),
        .b     (slice_y),
        .cin   (carry_reg),
        .sum   (slice_sum),
        .cout  (slice_cout),
`ifdef ADDSUB_FLAGS_EN
        .c_msb (slice_c_msb)
`else
        .c_msb (c_msb_unused)
`endif
    );

    // Result with the current slice merged in; the zero flag looks at this so
    // the final slice's sum is included on the edge it is written.
    always_comb begin
        d_next = d_reg;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_reg == IDXW'(i)) begin
                d_next[i*SLICE +: SLICE] = slice_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            a_reg     <= '0;
            y_reg     <= '0;
            carry_reg <= 1'b0;
            d_reg     <= '0;
            cout_reg  <= 1'b0;
`ifdef ADDSUB_FLAGS_EN
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        y_reg     <= y_sel;
                        carry_reg <= cin;
                        idx_reg   <= '0;
                        state_reg <= S_RUN;
                    end
                end
                S_RUN: begin
                    d_reg     <= d_next;
                    carry_reg <= slice_cout;
                    if (idx_reg == IDX_LAST) begin
                        cout_reg  <= slice_cout;
                        idx_reg   <= '0;
                        state_reg <= S_DONE;
`ifdef ADDSUB_FLAGS_EN
                        ovf_reg   <= slice_c_msb ^ slice_cout;
                        zero_reg  <= (d_next == '0);
`endif
                    end else begin
                        idx_reg <= idx_reg + IDXW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = (state_reg == S_DONE);
    assign d         = d_reg;
    assign cout      = cout_reg;
`ifdef ADDSUB_FLAGS_EN
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;
`endif

endmodule

// File: tb/tb_seq_cla_addsub.sv
// Directed self-checking bench for seq_cla_addsub (WIDTH=16, SLICE=4); the
// flag checks are compiled in when ADDSUB_FLAGS_EN is defined.
module tb_seq_cla_addsub;

    localparam int NSL = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] d;
    logic        cout;
`ifdef ADDSUB_FLAGS_EN
    logic        ovf;
    logic        zero;
`endif

    int checks = 0;
    int errors = 0;

    seq_cla_addsub #(
        .WIDTH (16),
        .SLICE (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
`ifdef ADDSUB_FLAGS_EN
        .ovf       (ovf),
        .zero      (zero),
`endif
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble the inputs after accept, and check latency.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [1:0] top, input logic tcin,
                          input logic [15:0] exp_d, input logic exp_cout);
        check({tag, "/ready"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_v; op = top; cin = tcin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); op = 2'($urandom); cin = 1'($urandom);
        check({tag, "/busy0"}, 32'(in_ready), 32'd0);
        for (int k = 1; k <= NSL; k++) begin
            @(posedge clk); #1;
            check({tag, "/lat"}, 32'(out_valid), (k == NSL) ? 32'd1 : 32'd0);
            check({tag, "/busy"}, 32'(in_ready), 32'd0);
        end
        check({tag, "/d"}, 32'(d), 32'(exp_d));
        check({tag, "/cout"}, 32'(cout), 32'(exp_cout));
        $display("op %s: a=%h b=%h op=%0d cin=%0d -> d=%h cout=%0d", tag, ta, tb_v, top, tcin, d, cout);
    endtask

    task automatic accept_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "/idle"}, 32'(in_ready), 32'd1);
        check({tag, "/ovdrop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        a = 16'h1111; b = 16'h2222; op = 2'b00; cin = 1'b0;
        #12;
        check("rst/in_ready", 32'(in_ready), 32'd1);
        check("rst/out_valid", 32'(out_valid), 32'd0);
        check("rst/d", 32'(d), 32'd0);
        check("rst/cout", 32'(cout), 32'd0);
        in_valid = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst/idle_after", 32'(in_ready), 32'd1);
        $display("reset: in_ready=%0d out_valid=%0d d=%h", in_ready, out_valid, d);

        run_op("add", 16'h1234, 16'h1111, 2'b00, 1'b0, 16'h2345, 1'b0);
        accept_result("add");
        run_op("sub5_7", 16'd5, 16'd7, 2'b01, 1'b1, 16'hFFFE, 1'b0);
        accept_result("sub5_7");
        run_op("sub7_5", 16'd7, 16'd5, 2'b01, 1'b1, 16'h0002, 1'b1);
        accept_result("sub7_5");
        run_op("inc", 16'hFFFF, 16'h1234, 2'b10, 1'b1, 16'h0000, 1'b1);
        accept_result("inc");
        run_op("dec", 16'h0000, 16'h5678, 2'b11, 1'b0, 16'hFFFF, 1'b0);
        accept_result("dec");

        // Back-pressure in DONE with a competing request on the input.
        run_op("hold", 16'h00FF, 16'h0F01, 2'b00, 1'b0, 16'h1000, 1'b0);
        a = 16'hAAAA; b = 16'h5555; op = 2'b00; cin = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("hold/d", 32'(d), 32'h1000);
            check("hold/cout", 32'(cout), 32'd0);
            check("hold/out_valid", 32'(out_valid), 32'd1);
            check("hold/in_ready", 32'(in_ready), 32'd0);
            $display("hold cycle %0d: d=%h out_valid=%0d in_ready=%0d", k, d, out_valid, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold/release_ready", 32'(in_ready), 32'd1);
        check("hold/release_ov", 32'(out_valid), 32'd0);
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        check("hold/not_taken", 32'(in_ready), 32'd1);

        // Reset two RUN cycles into an operation.
        a = 16'h1234; b = 16'h1111; op = 2'b00; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("abort/pre_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort/out_valid", 32'(out_valid), 32'd0);
        check("abort/d", 32'(d), 32'd0);
        check("abort/cout", 32'(cout), 32'd0);
        check("abort/in_ready", 32'(in_ready), 32'd1);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort/idle_after", 32'(in_ready), 32'd1);
        $display("abort: d=%h cout=%0d in_ready=%0d", d, cout, in_ready);
        run_op("after_abort", 16'h0001, 16'h0001, 2'b00, 1'b0, 16'h0002, 1'b0);
        accept_result("after_abort");

`ifdef ADDSUB_FLAGS_EN
        run_op("ovf_pos", 16'h7FFF, 16'h0001, 2'b00, 1'b0, 16'h8000, 1'b0);
        check("ovf_pos/ovf", 32'(ovf), 32'd1);
        check("ovf_pos/zero", 32'(zero), 32'd0);
        accept_result("ovf_pos");
        run_op("ovf_neg", 16'h8000, 16'h8000, 2'b00, 1'b0, 16'h0000, 1'b1);
        check("ovf_neg/ovf", 32'(ovf), 32'd1);
        check("ovf_neg/zero", 32'(zero), 32'd1);
        accept_result("ovf_neg");
        run_op("noflag", 16'h1234, 16'h1111, 2'b00, 1'b0, 16'h2345, 1'b0);
        check("noflag/ovf", 32'(ovf), 32'd0);
        check("noflag/zero", 32'(zero), 32'd0);
        accept_result("noflag");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
